// File: rtl/ram_fifo_if.sv
// ram_fifo_if: handshake and status bundle for ram_fifo.
//   Write side : wr_valid, wr_ready, wr_data
//   Read side  : rd_valid, rd_ready, rd_data (show-ahead)
//   Status     : count, full, empty, almost_full, almost_empty, max_count
// modport master is the producer/consumer side; modport slave is the FIFO.
interface ram_fifo_if #(
   parameter int unsigned NBits = 8,
   parameter int unsigned NAddr = 3
);
   logic             wr_valid;
   logic             wr_ready;
   logic [NBits-1:0] wr_data;
   logic             rd_valid;
   logic             rd_ready;
   logic [NBits-1:0] rd_data;
   logic [NAddr:0]   count;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [NAddr:0]   max_count;

   modport master (
      output wr_valid, wr_data, rd_ready,
      input  wr_ready, rd_valid, rd_data, count, full, empty,
             almost_full, almost_empty, max_count
   );

   modport slave (
      input  wr_valid, wr_data, rd_ready,
      output wr_ready, rd_valid, rd_data, count, full, empty,
             almost_full, almost_empty, max_count
   );
endinterface

// File: rtl/ram_fifo.sv
// ram_fifo: synchronous FIFO on a 2**NAddr x NBits RAM array with valid/ready
// handshakes and registered show-ahead read data.
// Ports:
//   MAX10_CLK1_50 : clock, all state on rising edge
//   rst           : asynchronous reset, active-low
//   bus           : ram_fifo_if.slave (write/read handshakes and status)
// Optional feature: define RAM_FIFO_WATERMARK_EN to build the max_count
// high-water-mark register; otherwise max_count is tied to zero.
module ram_fifo #(
   parameter int unsigned NBits     = 8,
   parameter int unsigned NAddr     = 3,
   parameter int unsigned AFULL_TH  = 6,
   parameter int unsigned AEMPTY_TH = 1
) (
   input  logic       MAX10_CLK1_50,
   input  logic       rst,
   ram_fifo_if.slave  bus
);
   localparam int unsigned Depth = 2 ** NAddr;
   localparam int unsigned CntW  = NAddr + 1;

   logic [NBits-1:0] mem [Depth];

   logic [NAddr-1:0] wr_ptr_q, wr_ptr_d;
   logic [NAddr-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic [CntW-1:0]  held_after_pop;
   logic             rd_valid_q, rd_valid_d;
   logic [NBits-1:0] rd_data_q, rd_data_d;
   logic             wr_ready_q, wr_ready_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             afull_q, afull_d;
   logic             aempty_q, aempty_d;
   logic             push, pop;

   assign push = bus.wr_valid & wr_ready_q;
   assign pop  = bus.rd_ready & rd_valid_q;

   // Next-state: pointers, occupancy, head register and registered flags.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;

      if (push) wr_ptr_d = wr_ptr_q + NAddr'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + NAddr'(1);

      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase

      // Only words already in the array may be presented; a word pushed on
      // this edge shows up one edge later. The array is read asynchronously,
      // so the word written on the previous edge is already visible here and
      // serves as the bypass for back-to-back pops.
      held_after_pop = count_q - CntW'(pop);
      rd_valid_d     = (held_after_pop != '0);
      if (rd_valid_d && (!rd_valid_q || pop))
         rd_data_d = mem[rd_ptr_d];

      full_d     = (count_d == CntW'(Depth));
      wr_ready_d = ~full_d;
      empty_d    = (count_d == '0);
      afull_d    = (count_d >= CntW'(AFULL_TH));
      aempty_d   = (count_d <= CntW'(AEMPTY_TH));
   end

   // State registers.
   always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         wr_ready_q <= 1'b1;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         afull_q    <= (AFULL_TH == 0);
         aempty_q   <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         wr_ready_q <= wr_ready_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         afull_q    <= afull_d;
         aempty_q   <= aempty_d;
      end
   end

   // Storage array; contents survive reset.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (push) mem[wr_ptr_q] <= bus.wr_data;
   end

`ifdef RAM_FIFO_WATERMARK_EN
   logic [CntW-1:0] max_count_q;

   // High-water mark of occupancy, cleared only by reset.
   always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
      if (!rst)                      max_count_q <= '0;
      else if (count_d > max_count_q) max_count_q <= count_d;
   end

   assign bus.max_count = max_count_q;
`else
   assign bus.max_count = '0;
`endif

   assign bus.wr_ready     = wr_ready_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.rd_data      = rd_data_q;
   assign bus.count        = count_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = afull_q;
   assign bus.almost_empty = aempty_q;
endmodule

// File: tb/tb_ram_fifo.sv
// tb_ram_fifo: directed self-checking bench for ram_fifo (DEPTH 8, AFULL_TH 6,
// AEMPTY_TH 1). Inputs change and outputs are sampled 1 ns after each edge.
module tb_ram_fifo;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;

`ifdef RAM_FIFO_WATERMARK_EN
   localparam bit WmEn = 1'b1;
`else
   localparam bit WmEn = 1'b0;
`endif

   ram_fifo_if #(.NBits(8), .NAddr(3)) bus ();

   ram_fifo #(.NBits(8), .NAddr(3), .AFULL_TH(6), .AEMPTY_TH(1)) dut (
      .MAX10_CLK1_50 (clk),
      .rst           (rst),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
      rst = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      step();
      tests++; if (bus.count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", bus.count); end
      tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
      tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", bus.full); end
      tests++; if (bus.wr_ready !== 1'b1) begin fails++; $display("FAIL reset_wr_ready got %b exp 1", bus.wr_ready); end
      tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got %b exp 0", bus.rd_valid); end
      tests++; if (bus.rd_data !== 8'h00) begin fails++; $display("FAIL reset_rd_data got %h exp 00", bus.rd_data); end
      tests++; if (bus.almost_empty !== 1'b1) begin fails++; $display("FAIL reset_aempty got %b exp 1", bus.almost_empty); end
      tests++; if (bus.almost_full !== 1'b0) begin fails++; $display("FAIL reset_afull got %b exp 0", bus.almost_full); end
      tests++; if (bus.max_count !== 4'd0) begin fails++; $display("FAIL reset_max_count got %0d exp 0", bus.max_count); end
   endtask

   task automatic test_single_word;
      bus.wr_valid = 1'b1; bus.wr_data = 8'hA5;
      step();
      bus.wr_valid = 1'b0;
      tests++; if (bus.count !== 4'd1) begin fails++; $display("FAIL single_count got %0d exp 1", bus.count); end
      tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL single_latency rd_valid got %b exp 0", bus.rd_valid); end
      step();
      tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hA5) begin fails++; $display("FAIL single_present got v=%b d=%h exp v=1 d=a5", bus.rd_valid, bus.rd_data); end
      for (int i = 0; i < 3; i++) begin
         step();
         tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hA5) begin fails++; $display("FAIL single_hold%0d got v=%b d=%h exp v=1 d=a5", i, bus.rd_valid, bus.rd_data); end
      end
      bus.rd_ready = 1'b1;
      step();
      bus.rd_ready = 1'b0;
      tests++; if (bus.empty !== 1'b1 || bus.rd_valid !== 1'b0 || bus.count !== 4'd0) begin fails++; $display("FAIL single_pop got e=%b v=%b c=%0d exp e=1 v=0 c=0", bus.empty, bus.rd_valid, bus.count); end
   endtask

   task automatic test_fill_order;
      for (int i = 1; i <= 8; i++) begin
         bus.wr_valid = 1'b1; bus.wr_data = 8'(i);
         step();
         tests++; if (bus.count !== 4'(i)) begin fails++; $display("FAIL fill_count%0d got %0d exp %0d", i, bus.count, i); end
         tests++; if (bus.almost_full !== (i >= 6)) begin fails++; $display("FAIL fill_afull%0d got %b exp %b", i, bus.almost_full, (i >= 6)); end
         tests++; if (bus.full !== (i == 8) || bus.wr_ready !== (i != 8)) begin fails++; $display("FAIL fill_full%0d got f=%b r=%b exp f=%b r=%b", i, bus.full, bus.wr_ready, (i == 8), (i != 8)); end
      end
      bus.wr_data = 8'h09;
      step();
      bus.wr_valid = 1'b0;
      tests++; if (bus.count !== 4'd8 || bus.full !== 1'b1) begin fails++; $display("FAIL fill_overflow got c=%0d f=%b exp c=8 f=1", bus.count, bus.full); end
      tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h01) begin fails++; $display("FAIL fill_head got v=%b d=%h exp v=1 d=01", bus.rd_valid, bus.rd_data); end
   endtask

   task automatic test_full_simultaneous;
      logic [7:0] exp_d;
      bus.wr_valid = 1'b1; bus.wr_data = 8'h55; bus.rd_ready = 1'b1;
      step();
      bus.rd_ready = 1'b0;
      tests++; if (bus.count !== 4'd7 || bus.wr_ready !== 1'b1 || bus.full !== 1'b0) begin fails++; $display("FAIL fullsim_pop got c=%0d r=%b f=%b exp c=7 r=1 f=0", bus.count, bus.wr_ready, bus.full); end
      tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h02) begin fails++; $display("FAIL fullsim_head got v=%b d=%h exp v=1 d=02", bus.rd_valid, bus.rd_data); end
      step();
      bus.wr_valid = 1'b0;
      tests++; if (bus.count !== 4'd8 || bus.full !== 1'b1) begin fails++; $display("FAIL fullsim_refill got c=%0d f=%b exp c=8 f=1", bus.count, bus.full); end
      // Drain without bubbles: 02..08 then 55.
      bus.rd_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_d = (k < 7) ? 8'(k + 2) : 8'h55;
         tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_d) begin fails++; $display("FAIL drain%0d got v=%b d=%h exp v=1 d=%h", k, bus.rd_valid, bus.rd_data, exp_d); end
         step();
      end
      bus.rd_ready = 1'b0;
      tests++; if (bus.empty !== 1'b1 || bus.rd_valid !== 1'b0) begin fails++; $display("FAIL drain_empty got e=%b v=%b exp e=1 v=0", bus.empty, bus.rd_valid); end
      tests++; if (bus.max_count !== (WmEn ? 4'd8 : 4'd0)) begin fails++; $display("FAIL drain_max_count got %0d exp %0d", bus.max_count, WmEn ? 8 : 0); end
   endtask

   task automatic test_wrap_around;
      logic [7:0] wv;
      logic [7:0] rv;
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
      wv = 8'h10; rv = 8'h10;
      for (int r = 0; r < 20; r++) begin
         for (int j = 0; j < 3; j++) begin
            bus.wr_valid = 1'b1; bus.wr_data = wv; wv++;
            step();
         end
         bus.wr_valid = 1'b0;
         tests++; if (bus.count !== 4'd3) begin fails++; $display("FAIL wrap_count r%0d got %0d exp 3", r, bus.count); end
         bus.rd_ready = 1'b1;
         for (int j = 0; j < 3; j++) begin
            tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== rv) begin fails++; $display("FAIL wrap_data r%0d j%0d got v=%b d=%h exp v=1 d=%h", r, j, bus.rd_valid, bus.rd_data, rv); end
            rv++;
            step();
         end
         bus.rd_ready = 1'b0;
      end
      tests++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin fails++; $display("FAIL wrap_end got c=%0d e=%b exp c=0 e=1", bus.count, bus.empty); end
      tests++; if (bus.max_count !== (WmEn ? 4'd3 : 4'd0)) begin fails++; $display("FAIL wrap_max_count got %0d exp %0d", bus.max_count, WmEn ? 3 : 0); end
   endtask

   task automatic test_reset_mid_stream;
      for (int i = 0; i < 5; i++) begin
         bus.wr_valid = 1'b1; bus.wr_data = 8'(8'hB0 + i);
         step();
      end
      bus.wr_valid = 1'b0;
      tests++; if (bus.count !== 4'd5) begin fails++; $display("FAIL midrst_pre got %0d exp 5", bus.count); end
      #2 rst = 1'b0;
      #1;
      tests++; if (bus.count !== 4'd0 || bus.rd_valid !== 1'b0 || bus.empty !== 1'b1) begin fails++; $display("FAIL midrst_async got c=%0d v=%b e=%b exp c=0 v=0 e=1", bus.count, bus.rd_valid, bus.empty); end
      tests++; if (bus.max_count !== 4'd0) begin fails++; $display("FAIL midrst_max_count got %0d exp 0", bus.max_count); end
      #1 rst = 1'b1;
      step();
      bus.wr_valid = 1'b1; bus.wr_data = 8'h3C;
      step();
      bus.wr_valid = 1'b0;
      step();
      tests++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h3C || bus.count !== 4'd1) begin fails++; $display("FAIL midrst_first got v=%b d=%h c=%0d exp v=1 d=3c c=1", bus.rd_valid, bus.rd_data, bus.count); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_fill_order();
      test_full_simultaneous();
      test_wrap_around();
      test_reset_mid_stream();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
